// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv_pkg
//  Description : Shared RV32I definitions for the decode/execute slice:
//                opcode constants, fetch-select codes, the canonical NOP,
//                funct3 encodings of ALU and branch operations and the
//                per-format immediate decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    localparam logic [1:0] FETCH_SEL_PC     = 2'd0;
    localparam logic [1:0] FETCH_SEL_BRANCH = 2'd1;
    localparam logic [1:0] FETCH_SEL_HOLD   = 2'd2;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_op_e;

    // Sign-extended immediate for the format implied by the opcode.
    function automatic logic [31:0] imm_decode(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: imm = {{20{instr[31]}}, instr[31:20]};
            STORE:              imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         imm = {instr[31:12], 12'b0};
            JAL:                imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                       instr[20], instr[30:21], 1'b0};
            default:            imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_alu.sv
`default_nettype none
// ============================================================================
//  Module      : rv_alu
//  Description : Combinational 10-operation RV32I ALU plus branch comparator.
//  Ports       : a, b      - operands (b is rs2 or immediate)
//                funct3    - operation select (ALU and branch share it)
//                alt       - selects SUB instead of ADD, SRA instead of SRL
//                result    - ALU result
//                br_taken  - branch condition holds
//                br_valid  - funct3 is a defined branch condition
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            alt,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            br_valid
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    always_comb begin
        result = '0;
        case (funct3)
            ALU_ADD:  result = alt ? (a - b) : (a + b);
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = alt ? XLEN'($signed(a) >>> w_shamt) : (a >> w_shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_valid = 1'b1;
        case (funct3)
            BR_EQ:   br_taken = (a == b);
            BR_NE:   br_taken = (a != b);
            BR_LT:   br_taken = ($signed(a) <  $signed(b));
            BR_GE:   br_taken = ($signed(a) >= $signed(b));
            BR_LTU:  br_taken = (a <  b);
            BR_GEU:  br_taken = (a >= b);
            default: br_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_cu_dec_ex.sv
`default_nettype none
// ============================================================================
//  Module      : rv_cu_dec_ex
//  Description : RV32I decode, decode/execute pipeline register, execute and
//                control for a 5-stage core. A taken branch/jump in EX
//                redirects fetch and squashes the two younger instructions.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                fetch_instr, fetch_pc      - instruction and its PC+4
//                rs1_addr, rs2_addr         - regfile read addresses
//                rs1_data, rs2_data         - regfile read data
//                fetch_sel, nop_fetch       - fetch redirect / squash
//                branch_taken/_target       - control-flow redirect
//                ex_result, ex_data, ex_rd  - EX result, store data, rd
//                store_mem, load_mem        - memory access type
//                store_reg, size            - writeback enable, access size
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_cu_dec_ex
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     fetch_instr,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [1:0]      fetch_sel,
    output logic            nop_fetch,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_data,
    output logic [4:0]      ex_rd,
    output logic            store_mem,
    output logic            load_mem,
    output logic            store_reg,
    output logic [2:0]      size
);

    // ---------------- decode ----------------
    assign rs1_addr = fetch_instr[19:15];
    assign rs2_addr = fetch_instr[24:20];

    logic [31:0] w_imm;
    assign w_imm = imm_decode(fetch_instr);

    // ---------------- D/E register ----------------
    logic [6:0]      r_opcode;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_funct7_5;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_pc;

    logic w_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_taken) begin
            if (!rst_n) begin
                r_opcode <= NOP_INSTR[6:0];
            end else begin
                r_opcode <= NOP_INSTR[6:0];
            end
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7_5 <= 1'b0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_pc       <= '0;
        end else begin
            r_opcode   <= fetch_instr[6:0];
            r_rd       <= fetch_instr[11:7];
            r_funct3   <= fetch_instr[14:12];
            r_funct7_5 <= fetch_instr[30];
            r_imm      <= w_imm;
            r_rs1      <= rs1_data;
            r_rs2      <= rs2_data;
            r_pc       <= fetch_pc;
        end
    end

    // ---------------- execute ----------------
    logic [XLEN-1:0] w_ipc;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_alu_b;
    logic            w_alt;
    logic [XLEN-1:0] w_alu_res;
    logic            w_br_taken;
    logic            w_br_valid;

    assign w_ipc   = r_pc - XLEN'(4);
    assign w_addr  = r_rs1 + r_imm;
    assign w_alu_b = (r_opcode == OP || r_opcode == BRANCH) ? r_rs2 : r_imm;

    // SUB exists only in the register form; SRA/SRAI in both forms.
    assign w_alt = r_funct7_5 &&
                   (((r_opcode == OP) && (r_funct3 == ALU_ADD || r_funct3 == ALU_SRL)) ||
                    ((r_opcode == OP_IMM) && (r_funct3 == ALU_SRL)));

    rv_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a        (r_rs1),
        .b        (w_alu_b),
        .funct3   (r_funct3),
        .alt      (w_alt),
        .result   (w_alu_res),
        .br_taken (w_br_taken),
        .br_valid (w_br_valid)
    );

    logic w_writes;

    always_comb begin
        ex_result     = '0;
        branch_target = '0;
        w_taken       = 1'b0;
        w_writes      = 1'b0;
        load_mem      = 1'b0;
        store_mem     = 1'b0;
        case (r_opcode)
            OP, OP_IMM: begin
                ex_result = w_alu_res;
                w_writes  = 1'b1;
            end
            LUI: begin
                ex_result = r_imm;
                w_writes  = 1'b1;
            end
            AUIPC: begin
                ex_result = w_ipc + r_imm;
                w_writes  = 1'b1;
            end
            LOAD: begin
                if (r_funct3 != 3'b011 && r_funct3 != 3'b110 && r_funct3 != 3'b111) begin
                    ex_result = w_addr;
                    load_mem  = 1'b1;
                    w_writes  = 1'b1;
                end
            end
            STORE: begin
                if (r_funct3 <= 3'b010) begin
                    ex_result = w_addr;
                    store_mem = 1'b1;
                end
            end
            JAL: begin
                ex_result     = r_pc;
                branch_target = w_ipc + r_imm;
                w_taken       = 1'b1;
                w_writes      = 1'b1;
            end
            JALR: begin
                if (r_funct3 == 3'b000) begin
                    ex_result     = r_pc;
                    branch_target = {w_addr[XLEN-1:1], 1'b0};
                    w_taken       = 1'b1;
                    w_writes      = 1'b1;
                end
            end
            BRANCH: begin
                if (w_br_valid) begin
                    branch_target = w_ipc + r_imm;
                    w_taken       = w_br_taken;
                end
            end
            default: begin
                ex_result = '0;
            end
        endcase
    end

    // ---------------- control ----------------
    assign branch_taken = w_taken;
    assign nop_fetch    = w_taken;
    assign fetch_sel    = w_taken ? FETCH_SEL_BRANCH : FETCH_SEL_PC;
    assign store_reg    = w_writes && (r_rd != 5'd0);
    assign ex_rd        = w_writes ? r_rd : 5'd0;
    assign ex_data      = r_rs2;
    assign size         = (load_mem || store_mem) ? r_funct3 : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_rv_cu_dec_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_cu_dec_ex
//  Description : Self-checking bench for rv_cu_dec_ex: table of single
//                instructions with hand-computed results, plus sequences
//                for reset, branch flush and reset during a pending flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_cu_dec_ex;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [1:0]  fetch_sel;
    logic        nop_fetch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] ex_result;
    logic [31:0] ex_data;
    logic [4:0]  ex_rd;
    logic        store_mem;
    logic        load_mem;
    logic        store_reg;
    logic [2:0]  size;

    rv_cu_dec_ex #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_instr   (fetch_instr),
        .fetch_pc      (fetch_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .fetch_sel     (fetch_sel),
        .nop_fetch     (nop_fetch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ex_result     (ex_result),
        .ex_data       (ex_data),
        .ex_rd         (ex_rd),
        .store_mem     (store_mem),
        .load_mem      (load_mem),
        .store_reg     (store_reg),
        .size          (size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        taken;
        logic [31:0] tgt;
        logic        chk_tgt;
        logic        sr;
        logic        ld;
        logic        st;
        logic [2:0]  sz;
        logic        chk_sz;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check_idle(input string tag);
        chk({tag, " branch_taken"}, 32'(branch_taken), 32'd0);
        chk({tag, " fetch_sel"},    32'(fetch_sel),    32'd0);
        chk({tag, " nop_fetch"},    32'(nop_fetch),    32'd0);
        chk({tag, " store_reg"},    32'(store_reg),    32'd0);
        chk({tag, " load_mem"},     32'(load_mem),     32'd0);
        chk({tag, " store_mem"},    32'(store_mem),    32'd0);
        chk({tag, " ex_rd"},        32'(ex_rd),        32'd0);
        chk({tag, " ex_result"},    ex_result,         32'd0);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        fetch_instr = instr;
        fetch_pc    = pc;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    initial begin
        logic [31:0] ins;
        string       t;

        //             instr          pc            rs1           rs2           result        rd    tk    tgt           ct    sr    ld    st    sz      cs
        vecs.push_back('{32'h002081B3, 32'h00000004, 32'd5,        32'd7,        32'd12,       5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // ADD
        vecs.push_back('{32'h402081B3, 32'h00000008, 32'h80000000, 32'd4,        32'h7FFFFFFC, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SUB
        vecs.push_back('{32'h4020D1B3, 32'h0000000C, 32'h80000000, 32'd4,        32'hF8000000, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SRA
        vecs.push_back('{32'h0020D1B3, 32'h00000010, 32'h80000000, 32'd4,        32'h08000000, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SRL
        vecs.push_back('{32'h4040D193, 32'h00000014, 32'h80000000, 32'd0,        32'hF8000000, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SRAI 4
        vecs.push_back('{32'h80008193, 32'h00000018, 32'h00001000, 32'd0,        32'h00000800, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // ADDI -2048 (no SUB)
        vecs.push_back('{32'h0020A1B3, 32'h0000001C, 32'hFFFFFFFF, 32'd1,        32'd1,        5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SLT
        vecs.push_back('{32'h0020B1B3, 32'h00000020, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SLTU
        vecs.push_back('{32'h002091B3, 32'h00000024, 32'd1,        32'h21,       32'd2,        5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // SLL uses [4:0]
        vecs.push_back('{32'h0020F1B3, 32'h00000028, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // AND
        vecs.push_back('{32'h0020C1B3, 32'h0000002C, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 5'd3, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // XOR
        vecs.push_back('{32'h123452B7, 32'h00000030, 32'd0,        32'd0,        32'h12345000, 5'd5, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // LUI
        vecs.push_back('{32'h00001297, 32'h00000104, 32'd0,        32'd0,        32'h00001100, 5'd5, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // AUIPC @0x100
        vecs.push_back('{32'h00412283, 32'h00000040, 32'h00001000, 32'h00000055, 32'h00001004, 5'd5, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1}); // LW x5,4(x2)
        vecs.push_back('{32'h00312423, 32'h00000044, 32'h00001000, 32'hDEADBEEF, 32'h00001008, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1}); // SW x3,8(x2)
        vecs.push_back('{32'h00500013, 32'h00000048, 32'd0,        32'd0,        32'd5,        5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // ADDI x0,x0,5
        vecs.push_back('{32'h02208063, 32'h00000104, 32'd9,        32'd9,        32'd0,        5'd0, 1'b1, 32'h00000120, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // BEQ taken
        vecs.push_back('{32'h02208063, 32'h00000104, 32'd9,        32'd8,        32'd0,        5'd0, 1'b0, 32'h00000120, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // BEQ not taken
        vecs.push_back('{32'h02209063, 32'h00000104, 32'd9,        32'd9,        32'd0,        5'd0, 1'b0, 32'h00000120, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // BNE equal
        vecs.push_back('{32'h0220C063, 32'h00000104, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0, 1'b1, 32'h00000120, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // BLT -1<1
        vecs.push_back('{32'h0220E063, 32'h00000104, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd0, 1'b0, 32'h00000120, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // BLTU
        vecs.push_back('{32'hFF9FF0EF, 32'h00000204, 32'd0,        32'd0,        32'h00000204, 5'd1, 1'b1, 32'h000001F8, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // JAL x1,-8
        vecs.push_back('{32'h000080E7, 32'h00000304, 32'h00000301, 32'd0,        32'h00000304, 5'd1, 1'b1, 32'h00000300, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0}); // JALR
        vecs.push_back('{32'h000001FF, 32'h00000308, 32'd3,        32'd4,        32'd0,        5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}); // unknown

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(32'h002081B3, 32'h4, 32'd5, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(NOP, 32'h4, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("nop_after_reset");

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            #1;
            ins = vecs[i].instr;
            t = $sformatf("v%0d", i);
            chk({t, " rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
            chk({t, " rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
            @(posedge clk);
            #1;
            chk({t, " ex_result"},    ex_result,             vecs[i].res);
            chk({t, " ex_rd"},        32'(ex_rd),            32'(vecs[i].rd));
            chk({t, " ex_data"},      ex_data,               vecs[i].rs2);
            chk({t, " branch_taken"}, 32'(branch_taken),     32'(vecs[i].taken));
            chk({t, " fetch_sel"},    32'(fetch_sel),        vecs[i].taken ? 32'd1 : 32'd0);
            chk({t, " nop_fetch"},    32'(nop_fetch),        32'(vecs[i].taken));
            chk({t, " store_reg"},    32'(store_reg),        32'(vecs[i].sr));
            chk({t, " load_mem"},     32'(load_mem),         32'(vecs[i].ld));
            chk({t, " store_mem"},    32'(store_mem),        32'(vecs[i].st));
            if (vecs[i].chk_tgt)
                chk({t, " branch_target"}, branch_target, vecs[i].tgt);
            if (vecs[i].chk_sz)
                chk({t, " size"}, 32'(size), 32'(vecs[i].sz));
            // separate vectors with a NOP so a flush never eats the next row
            @(negedge clk);
            drive(NOP, 32'h0, 32'd0, 32'd0);
            @(posedge clk);
        end

        // ---------------- taken branch flushes younger instruction ----------------
        @(negedge clk);
        drive(32'h02208063, 32'h104, 32'd1, 32'd1);     // BEQ taken
        @(posedge clk);
        #1;
        chk("flush beq taken", 32'(branch_taken), 32'd1);
        chk("flush beq target", branch_target, 32'h120);
        @(negedge clk);
        drive(32'h002081B3, 32'h108, 32'd5, 32'd7);     // ADD in shadow
        @(posedge clk);
        #1;
        check_idle("flushed_slot");
        @(negedge clk);
        drive(32'h002081B3, 32'h124, 32'd5, 32'd7);     // ADD at target
        @(posedge clk);
        #1;
        chk("after_flush ex_result", ex_result, 32'd12);
        chk("after_flush store_reg", 32'(store_reg), 32'd1);

        // ---------------- reset overrides pending flush ----------------
        @(negedge clk);
        drive(32'hFF9FF0EF, 32'h204, 32'd0, 32'd0);     // JAL
        @(posedge clk);
        #1;
        chk("rst_ovr jal taken", 32'(branch_taken), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        drive(32'h002081B3, 32'h8, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        check_idle("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset ex_result", ex_result, 32'd12);
        chk("post_reset ex_rd", 32'(ex_rd), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
